// File: rtl/simon_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : simon_serial_ctrl_if
// Description : Bundles the host-side byte/command port and the bit-serial
//               cipher port of simon_serial_ctrl.
//               slave  - controller view (drives status, ct and cipher mode)
//               master - environment view (drives host and cipher responses)
// Ports       : host_data[7:0], host_wr, host_sel, start   host -> ctrl
//               busy, done, err, ct[BLOCK_W-1:0]            ctrl -> host
//               cipher_data_rdy[1:0], cipher_data_in,
//               cipher_debug                                ctrl -> cipher
//               cipher_out, cipher_valid                    cipher -> ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface simon_serial_ctrl_if #(
  parameter int BLOCK_W = 64
);
  logic [7:0]         host_data;
  logic               host_wr;
  logic               host_sel;
  logic               start;
  logic               busy;
  logic               done;
  logic               err;
  logic [BLOCK_W-1:0] ct;
  logic [1:0]         cipher_data_rdy;
  logic               cipher_data_in;
  logic               cipher_debug;
  logic               cipher_out;
  logic               cipher_valid;

  modport slave (
    input  host_data, host_wr, host_sel, start, cipher_out, cipher_valid,
    output busy, done, err, ct, cipher_data_rdy, cipher_data_in, cipher_debug
  );

  modport master (
    output host_data, host_wr, host_sel, start, cipher_out, cipher_valid,
    input  busy, done, err, ct, cipher_data_rdy, cipher_data_in, cipher_debug
  );
endinterface
`default_nettype wire

// File: rtl/simon_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simon_serial_ctrl
// Description : Host-side controller for a bit-serial SIMON block cipher.
//               Collects key/plaintext bytes, streams them LSB first into the
//               cipher, waits (bounded) for the cipher output and captures the
//               serial ciphertext into a parallel register.
// Ports       : clk    - single clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - simon_serial_ctrl_if.slave (host + cipher signals)
// Revision    : 1.0 - initial release
// ============================================================================
module simon_serial_ctrl #(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  simon_serial_ctrl_if.slave bus
);

  localparam int C_CNT_W  = $clog2(KEY_W) + 1;
  localparam int C_TMO_W  = $clog2(TIMEOUT) + 1;
  localparam int C_KIDX_W = $clog2(KEY_W);
  localparam int C_BIDX_W = $clog2(BLOCK_W);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KEY = 3'd1,
    S_LOAD_PT  = 3'd2,
    S_ENCRYPT  = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t               r_state, w_state;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt;
  logic [C_TMO_W-1:0]   r_tmo, w_tmo;
  logic [KEY_W-1:0]     r_key, w_key;
  logic [BLOCK_W-1:0]   r_pt, w_pt;
  logic [BLOCK_W-1:0]   r_ct, w_ct;
  logic                 r_key_seen, w_key_seen;
  logic                 r_key_dirty, w_key_dirty;
  logic                 w_err;
  logic [C_BIDX_W-1:0]  w_cap_idx;
  logic [1:0]           w_rdy;
  logic                 w_din;

  // Registered outputs
  logic                 r_busy, r_done, r_err, r_din;
  logic [1:0]           r_rdy;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_tmo       = r_tmo;
    w_key       = r_key;
    w_pt        = r_pt;
    w_ct        = r_ct;
    w_key_seen  = r_key_seen;
    w_key_dirty = r_key_dirty;
    w_err       = 1'b0;
    // The first bit lands during the ENCRYPT->CAPTURE edge, so in CAPTURE
    // the bit being written is one ahead of the per-state counter.
    w_cap_idx   = r_cnt[C_BIDX_W-1:0] + C_BIDX_W'(1);

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          // A write coinciding with start is intentionally dropped.
          if (!r_key_seen) begin
            w_err = 1'b1;
          end else if (r_key_dirty) begin
            w_state = S_LOAD_KEY;
          end else begin
            w_state = S_LOAD_PT;
          end
        end else if (bus.host_wr) begin
          if (bus.host_sel) begin
            w_key       = {r_key[KEY_W-9:0], bus.host_data};
            w_key_seen  = 1'b1;
            w_key_dirty = 1'b1;
          end else begin
            w_pt = {r_pt[BLOCK_W-9:0], bus.host_data};
          end
        end
      end

      S_LOAD_KEY: begin
        if (r_cnt == C_CNT_W'(KEY_W - 1)) begin
          w_state     = S_LOAD_PT;
          w_key_dirty = 1'b0;
        end else begin
          w_cnt = r_cnt + C_CNT_W'(1);
        end
      end

      S_LOAD_PT: begin
        if (r_cnt == C_CNT_W'(BLOCK_W - 1)) begin
          w_state = S_ENCRYPT;
        end else begin
          w_cnt = r_cnt + C_CNT_W'(1);
        end
      end

      S_ENCRYPT: begin
        if (bus.cipher_valid) begin
          w_ct[0] = bus.cipher_out;
          w_state = S_CAPTURE;
        end else if (r_tmo == C_TMO_W'(TIMEOUT - 1)) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_tmo = r_tmo + C_TMO_W'(1);
        end
      end

      S_CAPTURE: begin
        if (bus.cipher_valid) begin
          w_ct[w_cap_idx] = bus.cipher_out;
          if (r_cnt == C_CNT_W'(BLOCK_W - 2)) begin
            w_state = S_DONE;
          end else begin
            w_cnt = r_cnt + C_CNT_W'(1);
          end
        end else begin
          // Cipher stream broke: its internal state is suspect, so force a
          // full key reload on the next run. ct keeps the partial capture.
          w_err       = 1'b1;
          w_key_dirty = 1'b1;
          w_state     = S_IDLE;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_state != r_state) begin
      w_cnt = '0;
      w_tmo = '0;
    end

    // Output decode for the state being entered, so the registered outputs
    // line up with the state register.
    w_rdy = 2'd0;
    w_din = 1'b0;
    case (w_state)
      S_LOAD_KEY: begin
        w_rdy = 2'd2;
        w_din = r_key[w_cnt[C_KIDX_W-1:0]];
      end
      S_LOAD_PT: begin
        w_rdy = 2'd1;
        w_din = r_pt[w_cnt[C_BIDX_W-1:0]];
      end
      S_ENCRYPT, S_CAPTURE: begin
        w_rdy = 2'd3;
      end
      default: begin
        w_rdy = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_key       <= '0;
      r_pt        <= '0;
      r_ct        <= '0;
      r_key_seen  <= 1'b0;
      r_key_dirty <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdy       <= 2'd0;
      r_din       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_key       <= w_key;
      r_pt        <= w_pt;
      r_ct        <= w_ct;
      r_key_seen  <= w_key_seen;
      r_key_dirty <= w_key_dirty;
      r_busy      <= (w_state != S_IDLE);
      r_done      <= (w_state == S_DONE);
      r_err       <= w_err;
      r_rdy       <= w_rdy;
      r_din       <= w_din;
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.err             = r_err;
  assign bus.ct              = r_ct;
  assign bus.cipher_data_rdy = r_rdy;
  assign bus.cipher_data_in  = r_din;
  assign bus.cipher_debug    = 1'b0;

endmodule
`default_nettype wire

// File: doc/simon_serial_ctrl.md
SIMON_SERIAL_CTRL -- requirements
Module: simon_serial_ctrl

Interface
REQ-001 Parameter BLOCK_W, default 64: plaintext/ciphertext width in bits.
REQ-002 Parameter KEY_W, default 128: key width in bits; BLOCK_W and KEY_W SHALL be multiples of 8.
REQ-003 Parameter TIMEOUT, default 4096: maximum ENCRYPT cycles to wait for cipher_valid.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 host_data  in  8  byte to load.
REQ-007 host_wr  in  1  byte-write strobe; one byte per high cycle.
REQ-008 host_sel  in  1  write target: 0 = plaintext register, 1 = key register.
REQ-009 start  in  1  single-cycle encryption request.
REQ-010 busy  out  1  high from the cycle after an accepted start until DONE exits.
REQ-011 done  out  1  one-cycle pulse; ct is valid in that cycle and afterwards.
REQ-012 err  out  1  one-cycle pulse on a rejected start, a timeout or a short capture.
REQ-013 ct  out  BLOCK_W  captured ciphertext, held until the next capture.
REQ-014 cipher_data_rdy  out  2  mode to the bit-serial cipher: 0 idle, 1 load plaintext, 2 load key, 3 encrypt.
REQ-015 cipher_data_in  out  1  serial bit to the cipher.
REQ-016 cipher_debug  out  1  debug select; tied to 0 (ciphertext readback).
REQ-017 cipher_out  in  1  serial bit from the cipher.
REQ-018 cipher_valid  in  1  cipher serial output qualifier.

Function
REQ-019 Byte load, IDLE only: on host_wr, the selected register shifts left 8 and host_data enters bits [7:0]; the last byte written becomes the LSB byte.
REQ-020 A key write SHALL set flag key_dirty and flag key_seen.
REQ-021 host_wr outside IDLE SHALL be ignored.
REQ-022 In IDLE, start has priority over host_wr: start is accepted and the write in the same cycle is dropped.
REQ-023 States: IDLE, LOAD_KEY, LOAD_PT, ENCRYPT, CAPTURE, DONE; all outputs are registered.
REQ-024 IDLE + start + !key_seen: remain in IDLE, pulse err, keep busy = 0.
REQ-025 IDLE + start + key_dirty: go to LOAD_KEY.
REQ-026 IDLE + start + key_seen + !key_dirty: go to LOAD_PT (key reuse).
REQ-027 LOAD_KEY: for exactly KEY_W cycles, cipher_data_rdy = 2 and cipher_data_in = key[k] in cycle k (LSB first); then clear key_dirty and go to LOAD_PT.
REQ-028 LOAD_PT: for exactly BLOCK_W cycles, cipher_data_rdy = 1 and cipher_data_in = pt[k]; then go to ENCRYPT.
REQ-029 ENCRYPT: cipher_data_rdy = 3 and cipher_data_in = 0, held until cipher_valid is sampled high; go to CAPTURE in the same edge, which captures the first bit.
REQ-030 ENCRYPT timeout: when TIMEOUT cycles elapse without cipher_valid, pulse err, leave ct unchanged and return to IDLE.
REQ-031 CAPTURE: the i-th sampled cipher_out (i = 0 at the first valid cycle) is written to ct bit i; after BLOCK_W bits go to DONE; cipher_data_rdy stays 3 throughout.
REQ-032 If cipher_valid drops before BLOCK_W bits are captured: pulse err, set key_dirty (forces a key reload) and return to IDLE; ct holds the partial shift.
REQ-033 DONE: one cycle with done = 1, busy = 1 and cipher_data_rdy = 0; then IDLE with busy = 0.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 Bit counter width SHALL be clog2(KEY_W) + 1 and SHALL reset to 0 on every state entry.
REQ-036 Latency, start to done with a dirty key: KEY_W + BLOCK_W + W + BLOCK_W + 1 cycles, where W = ENCRYPT wait; with key reuse, the KEY_W term drops out.

Reset
REQ-037 rst_n low at a clock edge: state = IDLE, busy = 0, done = 0, err = 0, cipher_data_rdy = 0, cipher_data_in = 0, ct = 0, pt = 0, key = 0, key_seen = 0, key_dirty = 0, counters = 0.
REQ-038 Reset asserted mid-operation SHALL abort on the same edge with no done or err pulse.

Verification
REQ-039 Simon64/128 vector: key 1b1a1918_13121110_0b0a0908_03020100, pt 656b696c_20646e75, start, with the real cipher -> done pulse, ct = 44c8fc20_b9dfa07a, no err.
REQ-040 Repeat start without a key write -> no LOAD_KEY cycles (cipher_data_rdy never 2), same ct, latency reduced by 128 cycles.
REQ-041 start after reset with no key written -> err pulse in the next cycle, busy stays 0, cipher_data_rdy stays 0.
REQ-042 Cipher model that never raises valid -> err after exactly 4096 ENCRYPT cycles, then IDLE, ct unchanged.
REQ-043 Valid dropped after 10 bits -> err pulse; the next start re-runs LOAD_KEY.
REQ-044 rst_n low during LOAD_PT cycle 20 -> all outputs at reset values on the next cycle, no done, no err; host_wr during busy leaves pt and key unchanged.
